spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter word_width, default 8, meaning the bits per SPI frame (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port SCK, input, 1 bit: serial clock from the master, asynchronous to clk.
REQ-005 SHALL have port SS, input, 1 bit: slave select, active-low, asynchronous.
REQ-006 SHALL have port MOSI, input, 1 bit: serial data from the master.
REQ-007 SHALL have port MISO, output, 1 bit: serial data to the master.
REQ-008 SHALL have port MISO_OE, output, 1 bit: MISO drive enable, high while the synchronized SS is low.
REQ-009 SHALL have port tx_data, input, word_width bits: word to transmit.
REQ-010 SHALL have port tx_load, input, 1 bit: write strobe for tx_data.
REQ-011 SHALL have port tx_ready, output, 1 bit: the TX buffer is empty.
REQ-012 SHALL have port rx_data, output, word_width bits: last complete received word.
REQ-013 SHALL have port rx_valid, output, 1 bit: one-cycle pulse marking a new rx_data.
REQ-014 SHALL have port busy, output, 1 bit: the state is SHIFT.

Function
REQ-015 SHALL pass SCK, SS and MOSI each through a 2-flop synchronizer and detect SCK edges by comparing against a third registered copy.
REQ-016 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first.
REQ-017 SHALL use states IDLE and SHIFT: IDLE->SHIFT on the synchronized SS falling; SHIFT->IDLE on the synchronized SS rising.
REQ-018 SHALL, on entering SHIFT, load the TX shift register from the TX buffer if it is full (the buffer becomes empty) or with all zeros otherwise, and clear the bit counter.
REQ-019 SHALL drive MISO from the TX shift register MSB and hold MISO at 0 when MISO_OE is low.
REQ-020 SHALL, on each detected SCK rising edge in SHIFT, shift the synchronized MOSI into the RX shift register LSB and increment the bit counter.
REQ-021 SHALL, on each detected SCK falling edge in SHIFT, shift the TX shift register left by one, except on a word boundary, where REQ-022 applies.
REQ-022 SHALL, on the rising edge that completes word_width bits (detected in cycle E), in cycle E+1 update rx_data, pulse rx_valid, zero the bit counter, and reload the TX shift register per REQ-018 at the next falling edge, so back-to-back frames work.
REQ-023 SHALL, when SS rises mid-word, discard the partial word with no rx_valid, zero the bit counter, and leave the TX buffer untouched.
REQ-024 SHALL hold rx_data between frames; rx_valid SHALL never be high for two consecutive cycles.
REQ-025 SHALL accept tx_load only when tx_ready=1, filling the buffer (tx_ready=0 next cycle); tx_load while tx_ready=0 SHALL be ignored.
REQ-026 SHALL give precedence to the shift-register load over a simultaneous tx_load: tx_load is accepted only if tx_ready was 1 in that cycle, and the load consumes the old content.
REQ-027 SHALL guarantee correct operation when SCK high and low phases are each at least 4 clk periods.

Reset
REQ-028 SHALL, while reset=1, force state IDLE, empty TX buffer (tx_ready=1), zero the shift registers and bit counter, rx_data=0, rx_valid=0, busy=0, MISO=0, MISO_OE=0, and clear the synchronizers to SCK=0, SS=1.
REQ-029 SHALL, on reset asserted mid-frame, abort the frame with no rx_valid, and resume only after the next synchronized SS falling edge.

Configuration
REQ-030 SHALL, with macro SPI_SLAVE_OVERRUN_EN defined, add output overrun (1 bit), set in cycle E+1 when rx_valid fires and the previous word's rx_valid was not acknowledged by a 1-cycle input rx_ack, and cleared by rx_ack or reset.
REQ-031 SHALL, without SPI_SLAVE_OVERRUN_EN, omit the overrun and rx_ack ports and their logic.

Verification
REQ-032 SHALL cover: tx_load 0xA5, then an 8-bit frame with master sending 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid pulse.
REQ-033 SHALL cover: a frame with no tx_load -> MISO all zeros; tx_ready stays 1.
REQ-034 SHALL cover: two back-to-back frames with SS held low, 0x11 loaded before the first and 0x22 during it -> MISO sends 0x11 then 0x22; rx_valid pulses twice.
REQ-035 SHALL cover: SS raised after 5 bits -> no rx_valid; rx_data unchanged; the next full frame receives correctly.
REQ-036 SHALL cover: reset for 1 cycle mid-frame -> all outputs at reset values next cycle; no rx_valid.
REQ-037 SHALL cover, with SPI_SLAVE_OVERRUN_EN defined: two frames without rx_ack -> overrun=1 after the second; rx_ack -> overrun=0.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 (CPOL=0, CPHA=0, MSB first) slave with SCK/SS/MOSI oversampled by clk.
// Define SPI_SLAVE_OVERRUN_EN to add the rx_ack input and the overrun status output.
module spi_slave #(
  parameter int word_width = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCK,
  input  logic                  SS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_OE,
  input  logic [word_width-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [word_width-1:0] rx_data,
  output logic                  rx_valid,
`ifdef SPI_SLAVE_OVERRUN_EN
  input  logic                  rx_ack,
  output logic                  overrun,
`endif
  output logic                  busy
);

  localparam int CW = (word_width > 2) ? $clog2(word_width) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(word_width - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state_reg, state_next;

  // Synchronizer bit order: [2]=SCK, [1]=SS, [0]=MOSI
  logic [2:0] meta_reg, sync_reg;
  logic       sck_prev_reg, ss_prev_reg;

  logic [word_width-1:0] tx_shift_reg, tx_buf_reg;
  logic                  tx_full_reg;
  logic [word_width-2:0] rx_shift_reg;
  logic [word_width-1:0] rx_data_reg;
  logic                  rx_valid_reg;
  logic [CW-1:0]         bit_cnt_reg;
  logic                  reload_reg;

  logic sck_sync, ss_sync, mosi_sync;
  logic sck_rise, sck_fall, ss_fall, ss_rise;
  logic enter_shift, leave_shift;
  logic shifting, word_end, tx_reload;
  logic [word_width-1:0] rx_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg     <= 3'b010;
      sync_reg     <= 3'b010;
      sck_prev_reg <= 1'b0;
      ss_prev_reg  <= 1'b1;
    end else begin
      meta_reg     <= {SCK, SS, MOSI};
      sync_reg     <= meta_reg;
      sck_prev_reg <= sync_reg[2];
      ss_prev_reg  <= sync_reg[1];
    end
  end

  assign sck_sync  = sync_reg[2];
  assign ss_sync   = sync_reg[1];
  assign mosi_sync = sync_reg[0];

  assign sck_rise = sck_sync & ~sck_prev_reg;
  assign sck_fall = ~sck_sync & sck_prev_reg;
  assign ss_fall  = ~ss_sync & ss_prev_reg;
  assign ss_rise  = ss_sync & ~ss_prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    enter_shift = 1'b0;
    leave_shift = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ss_fall) begin
          state_next  = SHIFT;
          enter_shift = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_next  = IDLE;
          leave_shift = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // SS rising wins over any SCK edge seen in the same cycle
  assign shifting  = (state_reg == SHIFT) && !ss_rise;
  assign word_end  = shifting && sck_rise && (bit_cnt_reg == LAST_BIT);
  assign tx_reload = enter_shift || (shifting && sck_fall && reload_reg);
  assign rx_word   = {rx_shift_reg, mosi_sync};

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_shift_reg <= '0;
      tx_buf_reg   <= '0;
      tx_full_reg  <= 1'b0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      bit_cnt_reg  <= '0;
      reload_reg   <= 1'b0;
    end else begin
      rx_valid_reg <= word_end;

      // The shift-register load consumes the buffer before a same-cycle tx_load is considered
      if (tx_reload) begin
        tx_shift_reg <= tx_full_reg ? tx_buf_reg : '0;
        tx_full_reg  <= 1'b0;
      end else if (shifting && sck_fall) begin
        tx_shift_reg <= {tx_shift_reg[word_width-2:0], 1'b0};
      end
      if (tx_load && !tx_full_reg) begin
        tx_buf_reg  <= tx_data;
        tx_full_reg <= 1'b1;
      end

      if (shifting && sck_rise) begin
        rx_shift_reg <= rx_word[word_width-2:0];
      end
      if (word_end) begin
        rx_data_reg <= rx_word;
      end

      if (enter_shift || leave_shift || word_end) begin
        bit_cnt_reg <= '0;
      end else if (shifting && sck_rise) begin
        bit_cnt_reg <= bit_cnt_reg + CW'(1);
      end

      // Next word's MSB goes out on the falling edge after the last sampled bit
      if (word_end) begin
        reload_reg <= 1'b1;
      end else if (tx_reload || leave_shift) begin
        reload_reg <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic pending_reg, overrun_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else if (word_end) begin
      pending_reg <= 1'b1;
      if (pending_reg && !rx_ack) begin
        overrun_reg <= 1'b1;
      end else if (rx_ack) begin
        overrun_reg <= 1'b0;
      end
    end else if (rx_ack) begin
      pending_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end
  end

  assign overrun = overrun_reg;
`endif

  assign MISO_OE  = ~ss_sync;
  assign MISO     = MISO_OE & tx_shift_reg[word_width-1];
  assign tx_ready = ~tx_full_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign busy     = (state_reg == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboarded bench for spi_slave: received words are queued at stimulus time and
// checked by an independent monitor on every rx_valid pulse.
module tb_spi_slave;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, SCK, SS, MOSI, MISO, MISO_OE;
  logic [W-1:0] tx_data, rx_data;
  logic         tx_load, tx_ready, rx_valid, busy;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic         rx_ack, overrun;
`endif

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] exp_word;
  logic [W-1:0] miso_a, miso_b;
  logic         prev_valid = 1'b0;

  always #5 clk = ~clk;

  spi_slave #(.word_width(W)) dut (
    .clk(clk), .reset(reset), .SCK(SCK), .SS(SS), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
`ifdef SPI_SLAVE_OVERRUN_EN
    .rx_ack(rx_ack), .overrun(overrun),
`endif
    .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end else begin
      $display("ok   %s: 0x%0h", name, actual);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_tx(input logic [W-1:0] v);
    tx_data = v;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  task automatic ss_low();
    SS = 1'b0;
    tick(8);
  endtask

  task automatic ss_high();
    tick(6);
    SS = 1'b1;
    tick(8);
  endtask

  // Mode 0 master: data set while SCK low, MISO sampled just before SCK rises
  task automatic spi_bits(input logic [W-1:0] mo, input int nbits, output logic [W-1:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = mo[W-1-i];
      tick(6);
      mi[W-1-i] = MISO;
      SCK = 1'b1;
      tick(6);
      SCK = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      check("rx_valid_single", {31'b0, prev_valid}, 32'h0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got rx_data 0x%0h expected no rx_valid", rx_data);
      end else begin
        exp_word = sb.pop_front();
        check("rx_data", {24'b0, rx_data}, {24'b0, exp_word});
      end
    end
    prev_valid = (rx_valid === 1'b1);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; SS = 1'b1; SCK = 1'b0; MOSI = 1'b0;
    tx_data = '0; tx_load = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
    rx_ack = 1'b0;
`endif
    tick(3);
    check("rst_tx_ready", {31'b0, tx_ready}, 32'h1);
    check("rst_rx_valid", {31'b0, rx_valid}, 32'h0);
    check("rst_busy",     {31'b0, busy},     32'h0);
    check("rst_miso",     {31'b0, MISO},     32'h0);
    check("rst_miso_oe",  {31'b0, MISO_OE},  32'h0);
    check("rst_rx_data",  {24'b0, rx_data},  32'h0);
    reset = 1'b0;
    tick(2);

    // Basic frame: send 0xA5, receive 0x3C
    load_tx(8'hA5);
    check("load_tx_ready", {31'b0, tx_ready}, 32'h0);
    sb.push_back(8'h3C);
    ss_low();
    check("sel_miso_oe", {31'b0, MISO_OE}, 32'h1);
    check("sel_busy",    {31'b0, busy},    32'h1);
    spi_bits(8'h3C, 8, miso_a);
    ss_high();
    check("miso_a5", {24'b0, miso_a}, 32'hA5);
    check("idle_busy", {31'b0, busy}, 32'h0);
    check("idle_oe",   {31'b0, MISO_OE}, 32'h0);

    // Frame with empty buffer: zeros out, buffer stays empty
    sb.push_back(8'h96);
    ss_low();
    spi_bits(8'h96, 8, miso_a);
    ss_high();
    check("miso_empty", {24'b0, miso_a}, 32'h0);
    check("empty_tx_ready", {31'b0, tx_ready}, 32'h1);

    // Back-to-back frames, second word loaded mid-frame
    load_tx(8'h11);
    sb.push_back(8'h5A);
    sb.push_back(8'hC3);
    ss_low();
    check("b2b_consumed", {31'b0, tx_ready}, 32'h1);
    load_tx(8'h22);
    spi_bits(8'h5A, 8, miso_a);
    spi_bits(8'hC3, 8, miso_b);
    ss_high();
    check("miso_b2b_1", {24'b0, miso_a}, 32'h11);
    check("miso_b2b_2", {24'b0, miso_b}, 32'h22);

    // Aborted partial frame, then a full frame
    ss_low();
    spi_bits(8'hFF, 5, miso_a);
    ss_high();
    check("partial_hold", {24'b0, rx_data}, 32'hC3);
    sb.push_back(8'h81);
    ss_low();
    spi_bits(8'h81, 8, miso_a);
    ss_high();
    check("after_partial_miso", {24'b0, miso_a}, 32'h0);

    // tx_load while buffer full is ignored
    load_tx(8'h77);
    check("full_tx_ready", {31'b0, tx_ready}, 32'h0);
    load_tx(8'h55);
    sb.push_back(8'h0F);
    ss_low();
    spi_bits(8'h0F, 8, miso_a);
    ss_high();
    check("miso_ignore", {24'b0, miso_a}, 32'h77);

    // One-cycle reset in the middle of a frame
    load_tx(8'hEE);
    ss_low();
    spi_bits(8'hAA, 3, miso_a);
    reset = 1'b1;
    tick(1);
    check("mid_rst_tx_ready", {31'b0, tx_ready}, 32'h1);
    check("mid_rst_rx_valid", {31'b0, rx_valid}, 32'h0);
    check("mid_rst_busy",     {31'b0, busy},     32'h0);
    check("mid_rst_miso",     {31'b0, MISO},     32'h0);
    check("mid_rst_miso_oe",  {31'b0, MISO_OE},  32'h0);
    check("mid_rst_rx_data",  {24'b0, rx_data},  32'h0);
    reset = 1'b0;
    SS = 1'b1;
    tick(10);
    check("post_rst_busy", {31'b0, busy}, 32'h0);
    sb.push_back(8'h24);
    ss_low();
    spi_bits(8'h24, 8, miso_a);
    ss_high();
    check("post_rst_miso", {24'b0, miso_a}, 32'h0);

`ifdef SPI_SLAVE_OVERRUN_EN
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    check("ovr_cleared", {31'b0, overrun}, 32'h0);
    sb.push_back(8'h01);
    ss_low();
    spi_bits(8'h01, 8, miso_a);
    ss_high();
    check("ovr_first", {31'b0, overrun}, 32'h0);
    sb.push_back(8'h02);
    ss_low();
    spi_bits(8'h02, 8, miso_a);
    ss_high();
    check("ovr_set", {31'b0, overrun}, 32'h1);
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    check("ovr_ack", {31'b0, overrun}, 32'h0);
`endif

    tick(20);
    check("sb_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
